bus_acq_arbiter: RTL and testbench
==================================

Name: bus_acq_arbiter

Overview:
- Round-robin bus-acquisition arbiter that shares a single framed bus between N_REQ requesters.
- Issues a one-hot grant and waits for the granted master to assert frame.
- Reports acquired while the master holds the bus.
- Enforces two timeouts: grant-to-frame (ACK_WAIT) and maximum tenure (MAX_TENURE), signalled by a one-cycle time_out pulse.
- Sits between the requesting masters and the shared bus, and is the sequencer behind the req/grant/frame/time_out/acquired protocol.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ACK_WAIT, 4, cycles grant may stay high without frame before time_out.
- MAX_TENURE, 64, maximum consecutive cycles of frame while acquired.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  request per master; level, held until served or withdrawn.
- frame  in  1  shared bus frame; high while the owning master uses the bus.
- grant  out  N_REQ  one-hot grant, registered; all-zero when the bus is unowned.
- acquired  out  1  high while the granted master holds frame (BUSY).
- owner  out  $clog2(N_REQ)  index of the current or last grantee.
- time_out  out  1  one-cycle pulse on grant-ack or tenure timeout.

Behaviour:
- Reset (rst sampled high at posedge):
  - state=IDLE; grant=0, acquired=0, time_out=0, owner=0.
  - rr_ptr=0 (requester 0 has highest priority); counters=0.
  - Applies from any state, mid-transaction included; outputs are zero on the cycle after the edge.
- Arbitration: the first set req bit scanning upward from rr_ptr, wrapping at N_REQ-1 to 0.
- IDLE:
  - Arbitrate only when frame=0 and req!=0.
  - req at edge t -> grant[i]=1, owner=i at t+1; go to GRANT; wait_cnt=0.
  - frame=1 in IDLE is ignored; no grant is issued until frame drops.
- GRANT:
  - Hold grant[i]; wait_cnt increments each cycle.
  - frame=1 -> BUSY; acquired=1 on the next cycle; ten_cnt=0.
  - req[i]=0 before frame -> IDLE; grant=0 next cycle; rr_ptr=i+1; no time_out.
  - wait_cnt reaches ACK_WAIT without frame -> time_out=1 for one cycle, grant=0 in the same cycle, go to RELEASE.
  - frame=1 in the same cycle the wait expires: frame wins (BUSY, no time_out).
- BUSY:
  - grant[i] and acquired are held; ten_cnt increments per cycle with frame=1.
  - frame=0 -> RELEASE; grant=0, acquired=0 next cycle; no time_out.
  - After MAX_TENURE consecutive frame-high cycles:
    - time_out pulses exactly MAX_TENURE cycles after acquired rose.
    - grant=0 and acquired=0 in the same cycle; go to RELEASE.
- RELEASE:
  - grant=0, acquired=0; rr_ptr=owner+1 mod N_REQ.
  - Stay while frame=1 (the bus must go idle after a forced release); frame=0 -> IDLE.
  - Minimum one turnaround cycle, so the earliest re-grant is 2 cycles after release.
- Invariants:
  - grant is one-hot or zero.
  - acquired implies grant!=0.
  - time_out is never high on two consecutive cycles.
  - owner is stable while grant!=0.
- Counter widths: $clog2(MAX_TENURE+1) and $clog2(ACK_WAIT+1); saturate, never wrap.

Decomposition:
- Package bus_acq_pkg:
  - state enum {IDLE, GRANT, BUSY, RELEASE} (2-bit).
  - Default values for N_REQ, ACK_WAIT and MAX_TENURE.
  - A function giving the counter width.
- Sub-module rr_picker: combinational round-robin first-one finder; inputs req and rr_ptr; outputs valid, index and one-hot.
- Top level: FSM, counters, output registers.

Test Plan:
- Basic cycle: req[0] at cycle 1; frame at 3, held for 10 cycles -> grant=4'b0001 at 2, acquired 4..13, grant=0 at 14, time_out never asserted.
- Tenure timeout: req[1] with frame held forever -> time_out pulse exactly 64 cycles after acquired rises; grant and acquired drop in the same cycle; no re-grant until frame=0.
- Ack timeout: req[2] granted, frame never asserted -> time_out at grant-rise+4; grant=0 in the same cycle; rr_ptr=3.
- Round robin: req=4'b1111 held; each master does a 2-cycle frame -> grant order 0,1,2,3,0 with no requester skipped or repeated.
- Withdraw: req[3] drops in GRANT -> grant=0 next cycle, no time_out. Frame and ACK_WAIT expiry coincide -> BUSY, no time_out.
- Reset mid-BUSY: rst high for 1 cycle -> grant=0, acquired=0, owner=0 next cycle; the next arbitration starts from requester 0.

Source files
------------

// File: rtl/bus_acq_pkg.sv
// Shared types and defaults for the round-robin bus-acquisition arbiter.
package bus_acq_pkg;

  localparam int N_REQ_DEF      = 4;
  localparam int ACK_WAIT_DEF   = 4;
  localparam int MAX_TENURE_DEF = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    BUSY    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Width of a saturating counter that must be able to hold max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bus_acq_arbiter_rr_picker.sv
// Round-robin first-one finder: scans req upward from rr_ptr, wrapping at N_REQ-1.
// Purely combinational; no flow control.
module rr_picker
  import bus_acq_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic [N_REQ-1:0]         onehot
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    valid    = 1'b0;
    idx      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = cand[IW-1:0];
      if (!valid && req[cand_idx]) begin
        valid = 1'b1;
        idx   = cand_idx;
      end
    end
    onehot = valid ? (ONE << idx) : '0;
  end

endmodule

// File: rtl/bus_acq_arbiter.sv
// Round-robin arbiter for a framed shared bus with grant-ack and tenure timeouts.
// Grant one cycle after req; a timeout drops grant and pulses time_out together.
module bus_acq_arbiter
  import bus_acq_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int ACK_WAIT   = ACK_WAIT_DEF,
  parameter int MAX_TENURE = MAX_TENURE_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic                     frame,
  output logic [N_REQ-1:0]         grant,
  output logic                     acquired,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     time_out
);

  localparam int IW = $clog2(N_REQ);
  localparam int WW = cnt_w(ACK_WAIT);
  localparam int TW = cnt_w(MAX_TENURE);
  localparam logic [WW-1:0] WAIT_LIM = WW'(ACK_WAIT);
  localparam logic [TW-1:0] TEN_LIM  = TW'(MAX_TENURE);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic             acquired_q, acquired_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic             time_out_q, time_out_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic [TW-1:0]    ten_cnt_q, ten_cnt_d;

  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]    owner_inc;
  logic [WW-1:0]    wait_inc;
  logic [TW-1:0]    ten_inc;

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_vld),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  // Saturating increments; the timeout fires when the incremented value reaches its limit.
  assign owner_inc = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
  assign wait_inc  = (wait_cnt_q >= WAIT_LIM) ? wait_cnt_q : wait_cnt_q + 1'b1;
  assign ten_inc   = (ten_cnt_q >= TEN_LIM) ? ten_cnt_q : ten_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    acquired_d = acquired_q;
    owner_d    = owner_q;
    time_out_d = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    ten_cnt_d  = ten_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (!frame && pick_vld) begin
          state_d    = GRANT;
          grant_d    = pick_oh;
          owner_d    = pick_idx;
          wait_cnt_d = '0;
        end
      end
      GRANT: begin
        if (frame) begin
          state_d    = BUSY;
          acquired_d = 1'b1;
          ten_cnt_d  = '0;
        end else if (!req[owner_q]) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = owner_inc;
        end else if (wait_inc >= WAIT_LIM) begin
          state_d    = RELEASE;
          grant_d    = '0;
          time_out_d = 1'b1;
          rr_ptr_d   = owner_inc;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      BUSY: begin
        if (!frame) begin
          state_d    = RELEASE;
          grant_d    = '0;
          acquired_d = 1'b0;
          rr_ptr_d   = owner_inc;
        end else if (ten_inc >= TEN_LIM) begin
          state_d    = RELEASE;
          grant_d    = '0;
          acquired_d = 1'b0;
          time_out_d = 1'b1;
          rr_ptr_d   = owner_inc;
        end else begin
          ten_cnt_d = ten_inc;
        end
      end
      RELEASE: begin
        // A forcibly released master may still be driving frame; wait for the bus to go idle.
        if (!frame) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      acquired_q <= 1'b0;
      owner_q    <= '0;
      time_out_q <= 1'b0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      ten_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      acquired_q <= acquired_d;
      owner_q    <= owner_d;
      time_out_q <= time_out_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      ten_cnt_q  <= ten_cnt_d;
    end
  end

  assign grant    = grant_q;
  assign acquired = acquired_q;
  assign owner    = owner_q;
  assign time_out = time_out_q;

endmodule

// File: tb/tb_bus_acq_arbiter.sv
// Self-checking bench for bus_acq_arbiter: per-cycle vector table plus tenure and round-robin sequences.
module tb_bus_acq_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0;
  logic       frame = 1'b0;
  logic [3:0] grant;
  logic       acquired;
  logic [1:0] owner;
  logic       time_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       frame;
    logic [3:0] grant;
    logic       acq;
    logic [1:0] owner;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   rr_q[$];

  bus_acq_arbiter #(.N_REQ(4), .ACK_WAIT(4), .MAX_TENURE(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .frame    (frame),
    .grant    (grant),
    .acquired (acquired),
    .owner    (owner),
    .time_out (time_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] rq, input logic f,
                              input logic [3:0] g, input logic a, input logic [1:0] o,
                              input logic t, input int n);
    for (int i = 0; i < n; i++)
      vecs.push_back('{rst: r, req: rq, frame: f, grant: g, acq: a, owner: o, to: t});
  endfunction

  // Inputs change 1 time unit after the edge; outputs are compared at the same point after the next edge.
  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    rst   = v.rst;
    req   = v.req;
    frame = v.frame;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("v%0d_grant", idx), 32'(grant), 32'(e.grant));
    chk($sformatf("v%0d_acquired", idx), 32'(acquired), 32'(e.acq));
    chk($sformatf("v%0d_owner", idx), 32'(owner), 32'(e.owner));
    chk($sformatf("v%0d_time_out", idx), 32'(time_out), 32'(e.to));
  endtask

  // Protocol invariants sampled on the falling edge.
  logic       mon_en = 1'b0;
  logic       prev_to = 1'b0;
  logic [3:0] prev_grant = 4'b0;
  logic [1:0] prev_owner = 2'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("inv_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("inv_acq_has_grant", 32'(!acquired || (grant != 4'b0)), 32'd1);
      chk("inv_to_single", 32'(!(time_out && prev_to)), 32'd1);
      if (prev_grant != 4'b0 && grant != 4'b0)
        chk("inv_owner_stable", 32'(owner), 32'(prev_owner));
    end
    prev_to    = time_out;
    prev_grant = grant;
    prev_owner = owner;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int         got;
    logic       acq_held;
    logic       seen;
    logic [3:0] eg;
    int         e;

    // Reset and basic cycle
    add(1, 4'h0, 0, 4'h0, 0, 2'd0, 0, 2);
    add(0, 4'h0, 0, 4'h0, 0, 2'd0, 0, 1);
    add(0, 4'h1, 0, 4'h1, 0, 2'd0, 0, 2);
    add(0, 4'h1, 1, 4'h1, 1, 2'd0, 0, 10);
    add(0, 4'h0, 0, 4'h0, 0, 2'd0, 0, 2);
    // Withdraw in GRANT (rr_ptr=1 -> requester 3)
    add(0, 4'h8, 0, 4'h8, 0, 2'd3, 0, 1);
    add(0, 4'h0, 0, 4'h0, 0, 2'd3, 0, 2);
    // Frame arrives on the cycle ACK_WAIT would expire
    add(0, 4'h4, 0, 4'h4, 0, 2'd2, 0, 4);
    add(0, 4'h4, 1, 4'h4, 1, 2'd2, 0, 1);
    add(0, 4'h4, 0, 4'h0, 0, 2'd2, 0, 1);
    add(0, 4'h0, 0, 4'h0, 0, 2'd2, 0, 1);
    // Ack timeout, then all requesting: next pointer must be 3
    add(0, 4'h4, 0, 4'h4, 0, 2'd2, 0, 4);
    add(0, 4'h4, 0, 4'h0, 0, 2'd2, 1, 1);
    add(0, 4'h0, 0, 4'h0, 0, 2'd2, 0, 1);
    add(0, 4'hF, 0, 4'h8, 0, 2'd3, 0, 1);
    add(0, 4'h0, 0, 4'h0, 0, 2'd3, 0, 1);
    // Frame high in IDLE blocks arbitration
    add(0, 4'h2, 1, 4'h0, 0, 2'd3, 0, 2);
    add(0, 4'h2, 0, 4'h2, 0, 2'd1, 0, 1);
    add(0, 4'h0, 0, 4'h0, 0, 2'd1, 0, 1);
    // Reset mid-BUSY, then arbitration restarts from requester 0
    add(0, 4'h8, 0, 4'h8, 0, 2'd3, 0, 1);
    add(0, 4'h8, 1, 4'h8, 1, 2'd3, 0, 2);
    add(1, 4'h8, 1, 4'h0, 0, 2'd0, 0, 1);
    add(0, 4'hF, 0, 4'h1, 0, 2'd0, 0, 1);
    add(0, 4'h0, 0, 4'h0, 0, 2'd0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
      if (i == 1) mon_en = 1'b1;
    end

    // Tenure timeout: rr_ptr=1, requester 1 holds frame indefinitely
    apply(1000, '{rst: 0, req: 4'h2, frame: 0, grant: 4'h2, acq: 0, owner: 2'd1, to: 0});
    apply(1001, '{rst: 0, req: 4'h2, frame: 1, grant: 4'h2, acq: 1, owner: 2'd1, to: 0});
    got = 0;
    acq_held = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk);
      #1;
      if (time_out) begin
        got = c;
        break;
      end
      if (!acquired) acq_held = 1'b0;
    end
    chk("tenure_cycles", 32'(got), 32'd64);
    chk("tenure_acq_held", 32'(acq_held), 32'd1);
    chk("tenure_grant_drop", 32'(grant), 32'd0);
    chk("tenure_acq_drop", 32'(acquired), 32'd0);
    for (int i = 0; i < 5; i++)
      apply(1010 + i, '{rst: 0, req: 4'h2, frame: 1, grant: 4'h0, acq: 0, owner: 2'd1, to: 0});
    apply(1020, '{rst: 0, req: 4'h2, frame: 0, grant: 4'h0, acq: 0, owner: 2'd1, to: 0});
    apply(1021, '{rst: 0, req: 4'h2, frame: 0, grant: 4'h2, acq: 0, owner: 2'd1, to: 0});
    apply(1022, '{rst: 0, req: 4'h0, frame: 0, grant: 4'h0, acq: 0, owner: 2'd1, to: 0});

    // Round robin with all four requesting, each doing a 2-cycle frame
    apply(2000, '{rst: 1, req: 4'h0, frame: 0, grant: 4'h0, acq: 0, owner: 2'd0, to: 0});
    rst = 1'b0;
    req = 4'hF;
    frame = 1'b0;
    rr_q.push_back(0);
    rr_q.push_back(1);
    rr_q.push_back(2);
    rr_q.push_back(3);
    rr_q.push_back(0);
    for (int n = 0; n < 5; n++) begin
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        if (grant != 4'b0) begin
          seen = 1'b1;
          break;
        end
      end
      chk($sformatf("rr%0d_seen", n), 32'(seen), 32'd1);
      e  = rr_q.pop_front();
      eg = 4'(1 << e);
      chk($sformatf("rr%0d_grant", n), 32'(grant), 32'(eg));
      chk($sformatf("rr%0d_owner", n), 32'(owner), 32'(e));
      frame = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_acquired", n), 32'(acquired), 32'd1);
      @(posedge clk);
      #1;
      frame = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_release", n), 32'(grant), 32'd0);
    end
    req = 4'h0;
    repeat (4) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
